wb_regfile_unpack: RTL and testbench
====================================

Name: wb_regfile_unpack

Overview:
Consumer end of the packed MEM/WB bus {reg_write, reg_dest[3:0], data[7:0]}.
- Unpacks the bus, commits writes into a 16 x 8-bit register file, and serves two combinational read ports with same-cycle write-through bypass.
- Writes to R15 are redirected as a one-cycle PC-load pulse.
- Holds a registered copy of the last committed write for second-level forwarding into EX.

Parameters:
DATA_W, 8, register/data width; bus bits [DATA_W-1:0]
ADDR_W, 4, register index width; bus bits [DATA_W+ADDR_W-1:DATA_W]
NREGS, 16, number of registers (2**ADDR_W)
PC_IDX, 15, register index treated as PC
BUS_W, 13, DATA_W+ADDR_W+1; MSB is reg_write

Ports:
nclk  in  1  clock; all state updates on posedge nclk
nrst  in  1  asynchronous active-low reset
wb_bus  in  BUS_W  packed MEM/WB bus: [7:0] data, [11:8] dest, [12] write enable
rd_addr_a  in  ADDR_W  read port A index
rd_addr_b  in  ADDR_W  read port B index
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
pc_load  out  1  registered one-cycle pulse: PC must load pc_value
pc_value  out  DATA_W  registered PC target
last_wb_valid  out  1  registered: a write committed on the previous edge
last_wb_dest  out  ADDR_W  registered index of that write
last_wb_data  out  DATA_W  registered data of that write
wr_count  out  8  registered count of committed writes

Behaviour:
- Decode: we = wb_bus[12]; dest = wb_bus[11:8]; wdata = wb_bus[7:0]. Ignore dest/data entirely when we=0, including X values.
- Reset (nrst low, asynchronous): all regs, pc_load, pc_value, last_wb_*, and wr_count go to 0 immediately. While nrst is low, rd_data_a/b are forced to 0.
- Reset asserted mid-operation drops any in-flight write and any pending pc_load. The first edge after nrst rises behaves normally.
- Write commit (posedge nclk, we=1):
  - regs[dest] <= wdata
  - last_wb_valid <= 1; last_wb_dest <= dest; last_wb_data <= wdata
  - wr_count <= wr_count + 1, wrapping 255 -> 0
- Edge with we=0: regs unchanged; last_wb_valid <= 0; last_wb_dest and last_wb_data hold their values.
- PC redirect: on an edge with we=1 and dest==PC_IDX, regs[15] is also written, pc_load <= 1 and pc_value <= wdata.
  - pc_load deasserts on the next edge unless that edge is again a PC write. Back-to-back PC writes give consecutive pulses; each pc_value updates.
  - pc_value holds when there is no PC write.
- Read ports, combinational, zero latency:
  - rd_data_x = wdata if we && dest==rd_addr_x, else regs[rd_addr_x].
  - Bypass applies to both ports independently, including when both address the same register, and including R15.
- Simultaneous read and write of the same register: the read sees the new data in the same cycle (write-through). The array holds it after the edge.
- All 16 registers are writable and readable. No hardwired zero register.
- Latency: write visible via bypass in cycle 0, via array from cycle 1. pc_load and last_wb_* visible from cycle 1.

Decomposition:
- Shared package holds the bus field constants:
  - WB_DATA_LSB=0, WB_DATA_MSB=7, WB_DEST_LSB=8, WB_DEST_MSB=11, WB_WE_BIT=12, WB_BUS_W=13
  - PC_IDX=15
  - Also used by the MEM/WB pipeline register so packing and unpacking share one definition.
- One natural sub-module: regfile_2r1w. It holds the 16x8 array, the single write port, two async reads and the bypass mux.
- Top level holds the decode, the PC-redirect registers, last_wb_* and wr_count.

Test Plan:
- Hold nrst=0 with wb_bus=13'h1FFF and pulse clocks -> all regs read 0, rd_data_a/b=0, pc_load=0, wr_count=0.
- wb_bus=13'h1_3A5 (we=1, dest=3, data=A5), rd_addr_a=3 -> rd_data_a=A5 before the edge. After the edge: regs[3]=A5, last_wb_valid=1, last_wb_dest=3, last_wb_data=A5, wr_count=1.
- wb_bus=13'h0_5FF (we=0, dest=5) for one edge -> regs[5] unchanged (0), last_wb_valid=0, last_wb_dest still 3, wr_count unchanged.
- wb_bus=13'h1_F40 then 13'h1_F44 on consecutive edges -> pc_load high for 2 cycles, pc_value 40 then 44. After one we=0 cycle: pc_load=0, pc_value=44, regs[15]=44.
- rd_addr_a=rd_addr_b=7 with a write of 7<-3C -> both ports read 3C in the same cycle. Then 256 writes -> wr_count wraps to the same value.
- Assert nrst for half a cycle while wb_bus targets R15 -> the write is dropped, pc_load stays 0, and all state reads 0 after release.

Source files
------------

// File: rtl/wb_regfile_unpack_pkg.sv
// rtl/wb_regfile_unpack_pkg.sv - MEM/WB bus field layout shared by packer and unpacker
package wb_regfile_unpack_pkg;

    localparam int WB_DATA_LSB = 0;
    localparam int WB_DATA_MSB = 7;
    localparam int WB_DEST_LSB = 8;
    localparam int WB_DEST_MSB = 11;
    localparam int WB_WE_BIT   = 12;
    localparam int WB_BUS_W    = 13;

    localparam int WB_DATA_W = WB_DATA_MSB - WB_DATA_LSB + 1;
    localparam int WB_ADDR_W = WB_DEST_MSB - WB_DEST_LSB + 1;
    localparam int WB_NREGS  = 2 ** WB_ADDR_W;
    localparam int PC_IDX    = 15;

    function automatic logic [WB_BUS_W-1:0] wb_pack(
        input logic                 we,
        input logic [WB_ADDR_W-1:0] dest,
        input logic [WB_DATA_W-1:0] data
    );
        return {we, dest, data};
    endfunction

endpackage

// File: rtl/wb_regfile_unpack_regfile_2r1w.sv
// rtl/wb_regfile_unpack_regfile_2r1w.sv - 2-read 1-write register array with write-through bypass
import wb_regfile_unpack_pkg::*;

module regfile_2r1w #(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int NREGS  = WB_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass compare is qualified by we first so X dest/data never leak when idle.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (rst_n) begin
            rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
            rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/wb_regfile_unpack.sv
// rtl/wb_regfile_unpack.sv - MEM/WB bus consumer: regfile commit, PC redirect, last-write forwarding
import wb_regfile_unpack_pkg::*;

module wb_regfile_unpack #(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int NREGS  = WB_NREGS,
    parameter int PC_REG = PC_IDX,
    parameter int BUS_W  = DATA_W + ADDR_W + 1
) (
    input  logic              nclk,
    input  logic              nrst,
    input  logic [BUS_W-1:0]  wb_bus,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_value,
    output logic              last_wb_valid,
    output logic [ADDR_W-1:0] last_wb_dest,
    output logic [DATA_W-1:0] last_wb_data,
    output logic [7:0]        wr_count
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

    logic              we;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] wdata;

    assign we    = wb_bus[BUS_W-1];
    assign dest  = wb_bus[DATA_W+ADDR_W-1:DATA_W];
    assign wdata = wb_bus[DATA_W-1:0];

    logic              pc_load_q,  pc_load_d;
    logic [DATA_W-1:0] pc_value_q, pc_value_d;
    logic              last_valid_q, last_valid_d;
    logic [ADDR_W-1:0] last_dest_q,  last_dest_d;
    logic [DATA_W-1:0] last_data_q,  last_data_d;
    logic [7:0]        wr_count_q,   wr_count_d;

    always_comb begin
        pc_load_d    = 1'b0;
        pc_value_d   = pc_value_q;
        last_valid_d = 1'b0;
        last_dest_d  = last_dest_q;
        last_data_d  = last_data_q;
        wr_count_d   = wr_count_q;
        if (we) begin
            last_valid_d = 1'b1;
            last_dest_d  = dest;
            last_data_d  = wdata;
            wr_count_d   = wr_count_q + 8'd1;
            if (dest == PC_ADDR) begin
                pc_load_d  = 1'b1;
                pc_value_d = wdata;
            end
        end
    end

    always_ff @(posedge nclk or negedge nrst) begin
        if (!nrst) begin
            pc_load_q    <= 1'b0;
            pc_value_q   <= '0;
            last_valid_q <= 1'b0;
            last_dest_q  <= '0;
            last_data_q  <= '0;
            wr_count_q   <= '0;
        end else begin
            pc_load_q    <= pc_load_d;
            pc_value_q   <= pc_value_d;
            last_valid_q <= last_valid_d;
            last_dest_q  <= last_dest_d;
            last_data_q  <= last_data_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // R15 is still written into the array so reads of the PC register stay coherent.
    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (nclk),
        .rst_n     (nrst),
        .we_i      (we),
        .waddr_i   (dest),
        .wdata_i   (wdata),
        .raddr_a_i (rd_addr_a),
        .raddr_b_i (rd_addr_b),
        .rdata_a_o (rd_data_a),
        .rdata_b_o (rd_data_b)
    );

    assign pc_load       = pc_load_q;
    assign pc_value      = pc_value_q;
    assign last_wb_valid = last_valid_q;
    assign last_wb_dest  = last_dest_q;
    assign last_wb_data  = last_data_q;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_wb_regfile_unpack.sv
// tb/tb_wb_regfile_unpack.sv - scoreboard bench for wb_regfile_unpack
module tb_wb_regfile_unpack;

    logic        nclk = 1'b0;
    logic        nrst;
    logic [12:0] wb_bus;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic        pc_load;
    logic [7:0]  pc_value;
    logic        last_wb_valid;
    logic [3:0]  last_wb_dest;
    logic [7:0]  last_wb_data;
    logic [7:0]  wr_count;

    int total = 0;
    int bad   = 0;

    typedef enum int {S_RDA, S_RDB, S_PCL, S_PCV, S_LV, S_LD, S_LDATA, S_CNT} sel_t;
    typedef struct {
        string      name;
        sel_t       sel;
        logic [7:0] exp;
    } exp_t;
    exp_t sb_q[$];

    wb_regfile_unpack dut (
        .nclk          (nclk),
        .nrst          (nrst),
        .wb_bus        (wb_bus),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .pc_load       (pc_load),
        .pc_value      (pc_value),
        .last_wb_valid (last_wb_valid),
        .last_wb_dest  (last_wb_dest),
        .last_wb_data  (last_wb_data),
        .wr_count      (wr_count)
    );

    always #5 nclk = ~nclk;

    function automatic logic [7:0] actual(input sel_t s);
        case (s)
            S_RDA:   return rd_data_a;
            S_RDB:   return rd_data_b;
            S_PCL:   return {7'd0, pc_load};
            S_PCV:   return pc_value;
            S_LV:    return {7'd0, last_wb_valid};
            S_LD:    return {4'd0, last_wb_dest};
            S_LDATA: return last_wb_data;
            default: return wr_count;
        endcase
    endfunction

    // Monitor: outputs are stable at the falling edge, so drain pending expectations there.
    always @(negedge nclk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [7:0] a;
            e = sb_q.pop_front();
            a = actual(e.sel);
            total++;
            if (a !== e.exp) begin
                bad++;
                $display("FAIL %s: got %02h expected %02h at %0t", e.name, a, e.exp, $time);
            end
        end
    end

    task automatic expect_val(input string name, input sel_t sel, input logic [7:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [12:0] bus, input logic [3:0] a, input logic [3:0] b);
        @(posedge nclk);
        #1;
        wb_bus    = bus;
        rd_addr_a = a;
        rd_addr_b = b;
    endtask

    initial begin
        nrst      = 1'b0;
        wb_bus    = 13'h1FFF;
        rd_addr_a = 4'd15;
        rd_addr_b = 4'd3;
        repeat (2) @(posedge nclk);
        #1;
        expect_val("rst_rda_forced", S_RDA, 8'h00);
        expect_val("rst_rdb", S_RDB, 8'h00);
        expect_val("rst_pc_load", S_PCL, 8'h00);
        expect_val("rst_pc_value", S_PCV, 8'h00);
        expect_val("rst_wr_count", S_CNT, 8'h00);
        expect_val("rst_last_valid", S_LV, 8'h00);

        step(13'h0000, 4'd0, 4'd1);
        nrst = 1'b1;
        expect_val("init_r0", S_RDA, 8'h00);
        expect_val("init_r1", S_RDB, 8'h00);
        for (int i = 1; i < 8; i++) begin
            step(13'h0000, 4'(2 * i), 4'(2 * i + 1));
            expect_val("init_reg_a", S_RDA, 8'h00);
            expect_val("init_reg_b", S_RDB, 8'h00);
        end

        step(13'h13A5, 4'd3, 4'd4);
        expect_val("bypass_r3", S_RDA, 8'hA5);
        expect_val("r4_untouched", S_RDB, 8'h00);

        step(13'h05FF, 4'd3, 4'd5);
        expect_val("array_r3", S_RDA, 8'hA5);
        expect_val("no_bypass_we0", S_RDB, 8'h00);
        expect_val("lv_after_write", S_LV, 8'h01);
        expect_val("ld_after_write", S_LD, 8'h03);
        expect_val("ldata_after_write", S_LDATA, 8'hA5);
        expect_val("cnt_after_write", S_CNT, 8'h01);
        expect_val("pcl_non_pc_write", S_PCL, 8'h00);

        step(13'h0000, 4'd5, 4'd3);
        expect_val("r5_unchanged", S_RDA, 8'h00);
        expect_val("r3_held", S_RDB, 8'hA5);
        expect_val("lv_idle", S_LV, 8'h00);
        expect_val("ld_hold", S_LD, 8'h03);
        expect_val("ldata_hold", S_LDATA, 8'hA5);
        expect_val("cnt_hold", S_CNT, 8'h01);

        step(13'h1F40, 4'd15, 4'd0);
        expect_val("bypass_r15", S_RDA, 8'h40);
        step(13'h1F44, 4'd15, 4'd0);
        expect_val("pcl_first", S_PCL, 8'h01);
        expect_val("pcv_first", S_PCV, 8'h40);
        expect_val("bypass_r15_2", S_RDA, 8'h44);
        expect_val("cnt_pc1", S_CNT, 8'h02);
        step(13'h0000, 4'd15, 4'd0);
        expect_val("pcl_second", S_PCL, 8'h01);
        expect_val("pcv_second", S_PCV, 8'h44);
        expect_val("cnt_pc2", S_CNT, 8'h03);
        expect_val("ld_pc", S_LD, 8'h0F);
        step(13'h0000, 4'd15, 4'd0);
        expect_val("pcl_drop", S_PCL, 8'h00);
        expect_val("pcv_hold", S_PCV, 8'h44);
        expect_val("r15_array", S_RDA, 8'h44);

        step(13'h173C, 4'd7, 4'd7);
        expect_val("dual_bypass_a", S_RDA, 8'h3C);
        expect_val("dual_bypass_b", S_RDB, 8'h3C);
        step(13'h0000, 4'd7, 4'd7);
        expect_val("dual_array_a", S_RDA, 8'h3C);
        expect_val("dual_array_b", S_RDB, 8'h3C);
        expect_val("cnt_before_wrap", S_CNT, 8'h04);

        for (int i = 0; i < 256; i++) begin
            step({5'b1_1000, 8'(i)}, 4'd8, 4'd7);
        end
        step(13'h0000, 4'd8, 4'd7);
        expect_val("cnt_wrap", S_CNT, 8'h04);
        expect_val("r8_last", S_RDA, 8'hFF);
        expect_val("r7_kept", S_RDB, 8'h3C);
        expect_val("ld_r8", S_LD, 8'h08);
        expect_val("ldata_r8", S_LDATA, 8'hFF);

        step(13'h1F99, 4'd15, 4'd8);
        expect_val("pre_rst_bypass", S_RDA, 8'h99);
        expect_val("pre_rst_pcl", S_PCL, 8'h00);
        @(negedge nclk);
        #1;
        nrst = 1'b0;
        @(posedge nclk);
        #1;
        nrst   = 1'b1;
        wb_bus = 13'h0000;
        expect_val("post_rst_pcl", S_PCL, 8'h00);
        expect_val("post_rst_pcv", S_PCV, 8'h00);
        expect_val("post_rst_cnt", S_CNT, 8'h00);
        expect_val("post_rst_lv", S_LV, 8'h00);
        expect_val("post_rst_ld", S_LD, 8'h00);
        expect_val("post_rst_ldata", S_LDATA, 8'h00);
        expect_val("post_rst_r15", S_RDA, 8'h00);
        expect_val("post_rst_r8", S_RDB, 8'h00);
        step(13'h0000, 4'd7, 4'd3);
        expect_val("post_rst_r7", S_RDA, 8'h00);
        expect_val("post_rst_r3", S_RDB, 8'h00);
        expect_val("post_rst_pcl2", S_PCL, 8'h00);

        repeat (2) @(negedge nclk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
